// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder
//
// Output reorder buffer for the 32-point radix-2 SDF FFT. The final butterfly
// stage emits each frame in bit-reversed index order; this block stores frames
// into a ping-pong pair of banks (address = bitrev(arrival count)) and reads
// them back linearly, so the output stream is in natural order X[0]..X[N-1].
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      in_r/in_i carry a sample
//   in_first   in   1      sample is bit-reversed index 0 of a frame
//   in_ready   out  1      a sample can be accepted this cycle
//   in_r/in_i  in   DW     input sample, signed 6.8
//   out_valid  out  1      out_r/out_i/out_idx are valid
//   out_ready  in   1      downstream accepts this cycle
//   out_r/out_i out DW     output sample, natural order (0 when not valid)
//   out_idx    out  LOG2N  natural frequency index (0 when not valid)
//   out_last   out  1      last sample of a frame
//   frame_err  out  1      one-cycle pulse: a partial frame was discarded
// -----------------------------------------------------------------------------
module fft_bitrev_reorder #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int DW    = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_first,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in_r,
  input  logic signed [DW-1:0]    in_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DW-1:0]    out_r,
  output logic signed [DW-1:0]    out_i,
  output logic [LOG2N-1:0]        out_idx,
  output logic                    out_last,
  output logic                    frame_err
);

  localparam logic [LOG2N-1:0] LP_LAST = LOG2N'(N - 1);

  function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = v[LOG2N-1-b];
    return r;
  endfunction

  // Sample storage: two banks, indexed [bank][address]
  logic signed [DW-1:0] r_mem_re [2][N];
  logic signed [DW-1:0] r_mem_im [2][N];

  logic [1:0]       r_full;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [LOG2N-1:0] r_wr_cnt;
  logic [LOG2N-1:0] r_rd_cnt;
  logic             r_frame_err;

  logic             w_wr_en;
  logic             w_resync;
  logic             w_wr_done;
  logic [LOG2N-1:0] w_wr_addr;
  logic             w_rd_en;
  logic             w_rd_done;
  logic [1:0]       w_full_nxt;

  assign in_ready  = !r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];

  assign w_wr_en   = in_valid && in_ready;
  // in_first in the middle of a frame restarts the frame at bit-reversed index 0
  assign w_resync  = w_wr_en && in_first && (r_wr_cnt != '0);
  assign w_wr_addr = w_resync ? '0 : f_bitrev(r_wr_cnt);
  assign w_wr_done = w_wr_en && !w_resync && (r_wr_cnt == LP_LAST);

  assign w_rd_en   = out_valid && out_ready;
  assign w_rd_done = w_rd_en && (r_rd_cnt == LP_LAST);

  // A write can only complete into an empty bank and a read can only release a
  // full one, so the two updates below never target the same bit.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_done) w_full_nxt[r_rd_bank] = 1'b0;
  end

  // NOTE: the sample banks carry no reset; validity is tracked entirely by
  // r_full, so stale contents are never observable and the array stays plain
  // flops/RAM without a reset network.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_re[r_wr_bank][w_wr_addr] <= in_r;
      r_mem_im[r_wr_bank][w_wr_addr] <= in_i;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_full      <= w_full_nxt;
      r_frame_err <= w_resync;

      if (w_wr_en) begin
        if (w_resync) begin
          r_wr_cnt <= LOG2N'(1);
        end else if (w_wr_done) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end

      if (w_rd_en) begin
        if (w_rd_done) begin
          r_rd_cnt  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end
    end
  end

  // Read port is combinational from the flop array; outputs are zeroed when idle
  assign out_r     = out_valid ? r_mem_re[r_rd_bank][r_rd_cnt] : '0;
  assign out_i     = out_valid ? r_mem_im[r_rd_bank][r_rd_cnt] : '0;
  assign out_idx   = out_valid ? r_rd_cnt : '0;
  assign out_last  = out_valid && (r_rd_cnt == LP_LAST);
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_bitrev_reorder
//
// Self-checking bench for fft_bitrev_reorder. A behavioural model keeps the
// partial input frame and the queue of reordered output samples; every cycle
// all DUT outputs are compared against it. Directed sequences cover reset,
// a ramp frame, back-to-back streaming, backpressure (table driven), resync
// and reset mid-drain; a randomized phase closes the run.
// -----------------------------------------------------------------------------
module tb_fft_bitrev_reorder;

  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int DW    = 14;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_first;
  logic                 in_ready;
  logic signed [DW-1:0] in_r;
  logic signed [DW-1:0] in_i;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_r;
  logic signed [DW-1:0] out_i;
  logic [LOG2N-1:0]     out_idx;
  logic                 out_last;
  logic                 frame_err;

  fft_bitrev_reorder #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: arrival-order partial frame, natural-order output queue
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } samp_t;

  samp_t m_part[$];
  samp_t m_out[$];
  int    m_rd_idx;
  bit    m_err;

  // statistics observed by cycle()
  int  n_cyc;
  int  n_valid_cyc;
  int  n_err_pulses;
  int  n_not_ready;
  int  first_valid_cyc;
  bit  chk_ramp;

  function automatic int bitrev(input int v);
    int r = 0;
    int x = v;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic int m_frames();
    return (m_out.size() + N - 1) / N;
  endfunction

  function automatic void model_reset();
    m_part.delete();
    m_out.delete();
    m_rd_idx = 0;
    m_err    = 1'b0;
  endfunction

  function automatic void clear_stats();
    n_cyc           = 0;
    n_valid_cyc     = 0;
    n_err_pulses    = 0;
    n_not_ready     = 0;
    first_valid_cyc = 0;
  endfunction

  // One clock cycle: inputs already driven; compare at the falling edge, then
  // advance the model across the rising edge.
  task automatic cycle(output bit acc);
    bit rd;
    @(negedge clk);
    n_cyc++;
    check("in_ready",  in_ready,  (m_frames() < 2) ? 1 : 0);
    check("out_valid", out_valid, (m_out.size() > 0) ? 1 : 0);
    check("frame_err", frame_err, m_err);
    if (m_out.size() > 0) begin
      check("out_r",    out_r,    m_out[0].re);
      check("out_i",    out_i,    m_out[0].im);
      check("out_idx",  out_idx,  m_rd_idx);
      check("out_last", out_last, (m_rd_idx == N - 1) ? 1 : 0);
      if (chk_ramp) begin
        check("ramp_re", out_r, m_rd_idx * 256);
        check("ramp_im", out_i, -(m_rd_idx * 256));
      end
    end else begin
      check("idle_r",    out_r,    0);
      check("idle_i",    out_i,    0);
      check("idle_idx",  out_idx,  0);
      check("idle_last", out_last, 0);
    end
    if (out_valid) begin
      n_valid_cyc++;
      if (first_valid_cyc == 0) first_valid_cyc = n_cyc;
    end
    if (frame_err) n_err_pulses++;
    if (!in_ready) n_not_ready++;

    acc = in_valid && (m_frames() < 2);
    rd  = (m_out.size() > 0) && out_ready;
    @(posedge clk);
    m_err = 1'b0;
    if (rd) begin
      void'(m_out.pop_front());
      m_rd_idx = (m_rd_idx + 1) % N;
    end
    if (acc) begin
      if (in_first && m_part.size() != 0) begin
        m_part.delete();
        m_err = 1'b1;
      end
      m_part.push_back('{re: in_r, im: in_i});
      if (m_part.size() == N) begin
        for (int n = 0; n < N; n++) m_out.push_back(m_part[bitrev(n)]);
        m_part.delete();
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    in_first = 1'b0;
    repeat (n) cycle(a);
  endtask

  // Offer n_samp samples as one frame; the k-th accepted sample carries
  // in_first at k==0. Ramp data: re=bitrev(k)<<8, im=-re.
  task automatic send(input int n_samp, input bit ramp);
    int k     = 0;
    int guard = 0;
    bit a;
    while (k < n_samp && guard < 10 * n_samp + 200) begin
      in_valid = 1'b1;
      in_first = (k == 0);
      if (ramp) begin
        in_r = DW'(bitrev(k % N) * 256);
        in_i = DW'(-(bitrev(k % N) * 256));
      end else begin
        in_r = DW'($urandom);
        in_i = DW'($urandom);
      end
      cycle(a);
      if (a) k++;
      guard++;
    end
    if (k < n_samp) check("send_timeout", k, n_samp);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  // Reset asserted mid-cycle; outputs must reach reset values without a clock.
  task automatic do_reset();
    #3;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r",     out_r,     0);
    check("rst_out_i",     out_i,     0);
    check("rst_out_idx",   out_idx,   0);
    check("rst_out_last",  out_last,  0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_frame_err", frame_err, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_stats();
  endtask

  // ---------------------------------------------------------------------------
  // Backpressure vectors: offer n_offer cycles of continuous input with a fixed
  // out_ready, then check accepted count and handshake state.
  // ---------------------------------------------------------------------------
  typedef struct {
    string name;
    int    n_offer;
    bit    out_rdy;
    int    exp_acc;
    bit    exp_in_ready;
    bit    exp_out_valid;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit a;
    int n_acc;
    int k;

    vecs[0] = '{name: "stall31", n_offer: 31, out_rdy: 1'b0, exp_acc: 31, exp_in_ready: 1'b1, exp_out_valid: 1'b0};
    vecs[1] = '{name: "stall32", n_offer: 32, out_rdy: 1'b0, exp_acc: 32, exp_in_ready: 1'b1, exp_out_valid: 1'b1};
    vecs[2] = '{name: "stall64", n_offer: 64, out_rdy: 1'b0, exp_acc: 64, exp_in_ready: 1'b0, exp_out_valid: 1'b1};
    vecs[3] = '{name: "stall80", n_offer: 80, out_rdy: 1'b0, exp_acc: 64, exp_in_ready: 1'b0, exp_out_valid: 1'b1};
    vecs[4] = '{name: "drain80", n_offer: 80, out_rdy: 1'b1, exp_acc: 80, exp_in_ready: 1'b1, exp_out_valid: 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_r      = '0;
    in_i      = '0;
    out_ready = 1'b1;
    chk_ramp  = 1'b0;
    model_reset();
    clear_stats();
    @(posedge clk);
    #1;

    // T1: reset values, asserted asynchronously mid-cycle
    do_reset();

    // T2: single ramp frame, natural-order output with fixed latency
    chk_ramp = 1'b1;
    send(N, 1'b1);
    idle(N + 4);
    chk_ramp = 1'b0;
    check("t2_first_valid_cycle", first_valid_cyc, N + 1);
    check("t2_valid_cycles",      n_valid_cyc,     N);

    // T3: four back-to-back frames at full rate
    do_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 4; f++) send(N, 1'b0);
    check("t3_offer_cycles", n_cyc, 4 * N);
    idle(N + 8);
    check("t3_in_ready_drops",    n_not_ready,     0);
    check("t3_first_valid_cycle", first_valid_cyc, N + 1);
    check("t3_valid_cycles",      n_valid_cyc,     4 * N);

    // T4: backpressure table
    foreach (vecs[v]) begin
      do_reset();
      out_ready = vecs[v].out_rdy;
      n_acc = 0;
      k     = 0;
      for (int c = 0; c < vecs[v].n_offer; c++) begin
        in_valid = 1'b1;
        in_first = ((k % N) == 0);
        in_r     = DW'($urandom);
        in_i     = DW'($urandom);
        cycle(a);
        if (a) begin
          n_acc++;
          k++;
        end
      end
      in_valid = 1'b0;
      in_first = 1'b0;
      @(negedge clk);
      check({vecs[v].name, "_accepted"},  n_acc,     vecs[v].exp_acc);
      check({vecs[v].name, "_in_ready"},  in_ready,  vecs[v].exp_in_ready);
      check({vecs[v].name, "_out_valid"}, out_valid, vecs[v].exp_out_valid);
      @(posedge clk);
      #1;
      // the extra edge above may have read a sample when out_ready=1; keep model aligned
      if (vecs[v].out_rdy && m_out.size() > 0) begin
        void'(m_out.pop_front());
        m_rd_idx = (m_rd_idx + 1) % N;
      end
      if (!vecs[v].out_rdy) idle(5);  // stalled outputs must hold frame 0, idx 0
      out_ready = 1'b1;
      idle(3 * N + 8);
      check({vecs[v].name, "_drained"}, out_valid, 0);
    end

    // T5: resync after 10 samples; partial frame must never appear
    do_reset();
    out_ready = 1'b1;
    send(10, 1'b0);
    send(N, 1'b0);
    idle(N + 4);
    check("t5_err_pulses",   n_err_pulses, 1);
    check("t5_valid_cycles", n_valid_cyc,  N);

    // T6: reset at out_idx==17, then one clean frame
    do_reset();
    out_ready = 1'b1;
    chk_ramp  = 1'b1;
    send(N, 1'b1);
    in_valid = 1'b0;
    k = 0;
    while (!(m_out.size() > 0 && m_rd_idx == 17) && k < 100) begin
      cycle(a);
      k++;
    end
    check("t6_reached_idx17", m_rd_idx, 17);
    check("t6_out_idx_before_rst", out_idx, 17);
    do_reset();
    send(N, 1'b1);
    idle(N + 4);
    chk_ramp = 1'b0;
    check("t6_valid_cycles", n_valid_cyc, N);

    // Randomized traffic with occasional resync and bursty backpressure
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_first  = (m_part.size() == 0) || ($urandom_range(0, 59) == 0);
      in_r      = DW'($urandom);
      in_i      = DW'($urandom);
      out_ready = ((c / 200) % 3 == 2) ? ($urandom_range(0, 7) == 0)
                                       : ($urandom_range(0, 2) != 0);
      cycle(a);
    end
    out_ready = 1'b1;
    idle(3 * N);
    check("rand_drained", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog: the run must terminate on its own
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
